traffic_light_monitor: RTL

- Passive checker on the light outputs (LA, LB) of the traffic-light controller FSM; it is the consumer end of that interface.
- Samples both roads' light codes every clock and checks encoding, mutual exclusion, legal colour sequence and minimum yellow dwell.
- Reports a sticky error with a first-fault code and counts completed signal rotations.
- Instantiated beside the controller in benches and the top level; never drives the controller.

---
 rtl/traffic_light_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the LA/LB light outputs of the
// traffic-light controller. Every clock it checks the encoding, mutual
// exclusion, colour sequence and yellow dwell of both roads. It latches a
// sticky first-fault code and counts road-A red->green rotations.
// It only observes the controller and never drives it.

module traffic_light_monitor #(
    parameter int unsigned YELLOW_MIN = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       LA,
    input  logic [1:0]       LB,
    input  logic             clr,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             err_pulse,
    output logic [CNT_W-1:0] rotations
);

    // Light encoding shared by both roads
    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Monitor FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // Fault codes
    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_BAD_SEQ  = 3'd3;
    localparam logic [2:0] CODE_SHORT_Y  = 3'd4;

    localparam logic [7:0] DWELL_MAX = 8'hFF;
    localparam logic [7:0] DWELL_MIN = 8'(YELLOW_MIN);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       prev_a;
    logic [1:0]       prev_b;
    logic [7:0]       dwell_a;
    logic [7:0]       dwell_b;
    logic [7:0]       dwell_a_nxt;
    logic [7:0]       dwell_b_nxt;
    logic             checking;
    logic             bad_code;
    logic             conflict;
    logic             bad_seq;
    logic             short_yel;
    logic [2:0]       viol_code;
    logic             viol;
    logic             err_nxt;
    logic [2:0]       err_code_nxt;
    logic             rot_hit;
    logic [CNT_W-1:0] rotations_nxt;

    // A step is legal if it holds or advances one colour G->Y->R->G.
    // Steps into or out of the illegal code are left to the encoding check.
    function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
        logic ok;
        ok = 1'b1;
        if (c != ILLEGAL) begin
            case (p)
                GREEN:   ok = (c == GREEN)  || (c == YELLOW);
                YELLOW:  ok = (c == YELLOW) || (c == RED);
                RED:     ok = (c == RED)    || (c == GREEN);
                default: ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

    // Dwell counter: 1 on the first yellow sample, then counts up to 255
    function automatic logic [7:0] dwell_step(input logic [1:0] c, input logic [7:0] d);
        logic [7:0] n;
        if (c != YELLOW) begin
            n = 8'd0;
        end else if (d == DWELL_MAX) begin
            n = d;
        end else begin
            n = d + 8'd1;
        end
        return n;
    endfunction

    // Sequence and dwell checks need a valid previous sample, so they are off in IDLE
    assign checking = (state != IDLE);

    // Evaluate all four checks on the current sample and pick the highest-priority fault
    always_comb begin
        bad_code  = (LA == ILLEGAL) || (LB == ILLEGAL);
        conflict  = (LA != RED) && (LB != RED);
        bad_seq   = checking && (!legal_step(prev_a, LA) || !legal_step(prev_b, LB));
        short_yel = checking &&
                    (((prev_a == YELLOW) && (LA == RED) && (dwell_a < DWELL_MIN)) ||
                     ((prev_b == YELLOW) && (LB == RED) && (dwell_b < DWELL_MIN)));
        if (bad_code) begin
            viol_code = CODE_ILLEGAL;
        end else if (conflict) begin
            viol_code = CODE_CONFLICT;
        end else if (bad_seq) begin
            viol_code = CODE_BAD_SEQ;
        end else if (short_yel) begin
            viol_code = CODE_SHORT_Y;
        end else begin
            viol_code = CODE_NONE;
        end
        viol = (viol_code != CODE_NONE);
    end

    // Next FSM state: any fault latches FAULT, clr leaves it only on a clean cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = viol ? FAULT : TRACK;
            TRACK:   state_nxt = viol ? FAULT : TRACK;
            FAULT:   state_nxt = (clr && !viol) ? TRACK : FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky flag and first-fault code; a new fault overrides clr in the same cycle
    always_comb begin
        err_nxt      = err;
        err_code_nxt = err_code;
        if (viol) begin
            err_nxt = 1'b1;
            if (!err || clr) begin
                err_code_nxt = viol_code;
            end
        end else if (clr) begin
            err_nxt      = 1'b0;
            err_code_nxt = CODE_NONE;
        end
    end

    // Rotation counter and yellow dwell next values
    always_comb begin
        rot_hit       = checking && (prev_a == RED) && (LA == GREEN);
        rotations_nxt = rotations;
        if (rot_hit && !(&rotations)) begin
            rotations_nxt = rotations + 1'b1;
        end
        dwell_a_nxt = dwell_step(LA, dwell_a);
        dwell_b_nxt = dwell_step(LB, dwell_b);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Previous-sample registers, updated every cycle including in FAULT
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_a <= GREEN;
            prev_b <= GREEN;
        end else begin
            prev_a <= LA;
            prev_b <= LB;
        end
    end

    // Per-road yellow dwell counters
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_a <= 8'd0;
            dwell_b <= 8'd0;
        end else begin
            dwell_a <= dwell_a_nxt;
            dwell_b <= dwell_b_nxt;
        end
    end

    // Error reporting registers; the pulse marks each violating sample
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_code  <= CODE_NONE;
            err_pulse <= 1'b0;
        end else begin
            err       <= err_nxt;
            err_code  <= err_code_nxt;
            err_pulse <= viol;
        end
    end

    // Saturating rotation counter, independent of errors and clr
    always_ff @(posedge clk) begin
        if (reset) begin
            rotations <= '0;
        end else begin
            rotations <= rotations_nxt;
        end
    end

endmodule
